mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM. Sequences the shared datapath (PC/NPC, IR, GRF, Ext, ALU, DM) one instruction at a time.

---
 rtl/mc_ctrl_pkg.sv | 38 +++
 rtl/mc_ctrl_decode.sv | 28 ++
 rtl/mc_ctrl.sv | 106 ++++++++++
 tb/tb_mc_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, opcode/funct constants, datapath select encodings and decode class type
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_OR = 2'd2, ALU_LUI = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_DM = 2'd1, WD_PC4 = 2'd2;
  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_RS = 2'd3;
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic undef;
  } cls_t;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: opcode/funct to one-hot instruction class
//  opcode, funct : IR[31:26], IR[5:0]
//  cls           : one-hot class, undef when nothing matches
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);
  logic r;
  always_comb begin
    r         = opcode == OP_RTYPE;
    cls       = '0;
    cls.addu  = r && funct == FN_ADDU;
    cls.subu  = r && funct == FN_SUBU;
    cls.jr    = r && funct == FN_JR;
    cls.nop   = r && funct == FN_NOP;
    cls.ori   = opcode == OP_ORI;
    cls.lui   = opcode == OP_LUI;
    cls.lw    = opcode == OP_LW;
    cls.sw    = opcode == OP_SW;
    cls.beq   = opcode == OP_BEQ;
    cls.jal   = opcode == OP_JAL;
    cls.undef = ~|{cls.addu, cls.subu, cls.jr, cls.nop, cls.ori, cls.lui,
                   cls.lw, cls.sw, cls.beq, cls.jal};
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM driving datapath selects and write enables
//  clk, reset     : clock, async active-high reset to S_FETCH
//  opcode, funct  : IR fields; zero : ALU equality flag in S_EXE
//  PCWr/IRWr/RegWr/MemWr : write enables; EXTop/ALUSrcB/ALUop/RegDst/WDSel/NPCop : selects
//  instr_done     : pulse in last state of each instruction; illegal : held undefined instruction
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit UNK_AS_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic       EXTop,
  output logic       ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCop,
  output logic       instr_done,
  output logic       illegal
);
  state_t state, nxt;
  cls_t   c;
  mc_ctrl_decode u_dec (.opcode(opcode), .funct(funct), .cls(c));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  always_comb begin
    nxt        = S_FETCH;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    MemWr      = 1'b0;
    EXTop      = 1'b0;
    ALUSrcB    = 1'b0;
    ALUop      = ALU_ADD;
    RegDst     = DST_RT;
    WDSel      = WD_ALU;
    NPCop      = NPC_PC4;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
        nxt  = S_DCD;
      end
      S_DCD: begin
        PCWr       = c.jal | c.jr;
        NPCop      = c.jal ? NPC_J : c.jr ? NPC_RS : NPC_PC4;
        RegWr      = c.jal;
        RegDst     = c.jal ? DST_RA : DST_RT;
        WDSel      = c.jal ? WD_PC4 : WD_ALU;
        illegal    = c.undef && !UNK_AS_NOP;
        instr_done = c.jal | c.jr | c.nop | (c.undef && UNK_AS_NOP);
        nxt        = illegal ? S_DCD : instr_done ? S_FETCH : S_EXE;
      end
      S_EXE: begin
        PCWr       = c.beq & zero;
        NPCop      = c.beq ? NPC_BR : NPC_PC4;
        instr_done = c.beq;
        nxt        = c.beq ? S_FETCH : (c.lw | c.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        MemWr      = c.sw;
        instr_done = c.sw;
        nxt        = c.lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWr      = 1'b1;
        instr_done = 1'b1;
        RegDst     = (c.addu | c.subu) ? DST_RD : DST_RT;
        WDSel      = c.lw ? WD_DM : WD_ALU;
      end
      default: nxt = S_FETCH;
    endcase
    // ALU and extender controls stay stable from EXE through MEM/WB so the result feeding DM/GRF holds
    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      ALUop   = (c.subu | c.beq) ? ALU_SUB : c.ori ? ALU_OR : c.lui ? ALU_LUI : ALU_ADD;
      ALUSrcB = c.ori | c.lui | c.lw | c.sw;
      EXTop   = c.lw | c.sw | c.beq;
    end
    // reset masks every output so no write can land while it is asserted
    if (reset) begin
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RegWr      = 1'b0;
      MemWr      = 1'b0;
      EXTop      = 1'b0;
      ALUSrcB    = 1'b0;
      ALUop      = ALU_ADD;
      RegDst     = DST_RT;
      WDSel      = WD_ALU;
      NPCop      = NPC_PC4;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl, both UNK_AS_NOP settings
module tb_mc_ctrl;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic PCWr, IRWr, RegWr, MemWr, EXTop, ALUSrcB, instr_done, illegal;
  logic [1:0] ALUop, RegDst, WDSel, NPCop;
  logic PCWr0, IRWr0, RegWr0, MemWr0, EXTop0, ALUSrcB0, instr_done0, illegal0;
  logic [1:0] ALUop0, RegDst0, WDSel0, NPCop0;
  logic [15:0] o, o0;
  int n_cmp = 0, n_bad = 0;
  // vector layout: {PCWr,IRWr,RegWr,MemWr}_{EXTop,ALUSrcB}_ALUop_RegDst_WDSel_NPCop_{instr_done,illegal}
  localparam logic [15:0] Z      = 16'b0000_00_00_00_00_00_00;
  localparam logic [15:0] F      = 16'b1100_00_00_00_00_00_00;
  localparam logic [15:0] ILL    = 16'b0000_00_00_00_00_00_01;
  localparam logic [15:0] DONE   = 16'b0000_00_00_00_00_00_10;
  always #5 clk = ~clk;
  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .EXTop(EXTop),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .RegDst(RegDst), .WDSel(WDSel),
    .NPCop(NPCop), .instr_done(instr_done), .illegal(illegal)
  );
  mc_ctrl #(.UNK_AS_NOP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr0), .IRWr(IRWr0), .RegWr(RegWr0), .MemWr(MemWr0), .EXTop(EXTop0),
    .ALUSrcB(ALUSrcB0), .ALUop(ALUop0), .RegDst(RegDst0), .WDSel(WDSel0),
    .NPCop(NPCop0), .instr_done(instr_done0), .illegal(illegal0)
  );
  assign o  = {PCWr, IRWr, RegWr, MemWr, EXTop, ALUSrcB, ALUop, RegDst, WDSel, NPCop, instr_done, illegal};
  assign o0 = {PCWr0, IRWr0, RegWr0, MemWr0, EXTop0, ALUSrcB0, ALUop0, RegDst0, WDSel0, NPCop0, instr_done0, illegal0};
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [15:0] exp);
    chk(tag, o, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask
  initial begin
    #1;
    chk("rst_all0", o, Z);
    chk("rst_all0_u0", o0, Z);
    ins(6'b000011, 6'd0);
    @(posedge clk);
    #1;
    chk("rst_mask_jal", o, Z);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    ins(6'b000000, 6'b100001);
    cyc("addu_f", F);
    cyc("addu_d", Z);
    cyc("addu_e", Z);
    cyc("addu_wb", 16'b0010_00_00_01_00_00_10);
    ins(6'b000000, 6'b100011);
    cyc("subu_f", F);
    cyc("subu_d", Z);
    cyc("subu_e", 16'b0000_00_01_00_00_00_00);
    cyc("subu_wb", 16'b0010_00_01_01_00_00_10);
    ins(6'b001101, 6'b000000);
    cyc("ori_f", F);
    cyc("ori_d", Z);
    cyc("ori_e", 16'b0000_01_10_00_00_00_00);
    cyc("ori_wb", 16'b0010_01_10_00_00_00_10);
    ins(6'b001111, 6'b000000);
    cyc("lui_f", F);
    cyc("lui_d", Z);
    cyc("lui_e", 16'b0000_01_11_00_00_00_00);
    cyc("lui_wb", 16'b0010_01_11_00_00_00_10);
    ins(6'b100011, 6'b000000);
    cyc("lw_f", F);
    cyc("lw_d", Z);
    cyc("lw_e", 16'b0000_11_00_00_00_00_00);
    cyc("lw_m", 16'b0000_11_00_00_00_00_00);
    cyc("lw_wb", 16'b0010_11_00_00_01_00_10);
    ins(6'b101011, 6'b000000);
    cyc("sw_f", F);
    cyc("sw_d", Z);
    cyc("sw_e", 16'b0000_11_00_00_00_00_00);
    cyc("sw_m", 16'b0001_11_00_00_00_00_10);
    ins(6'b000100, 6'b000000);
    zero = 1'b1;
    cyc("beq1_f", F);
    cyc("beq1_d", Z);
    cyc("beq1_e", 16'b1000_10_01_00_00_01_10);
    zero = 1'b0;
    cyc("beq0_f", F);
    cyc("beq0_d", Z);
    cyc("beq0_e", 16'b0000_10_01_00_00_01_10);
    ins(6'b000011, 6'b000000);
    cyc("jal_f", F);
    cyc("jal_d", 16'b1010_00_00_10_10_10_10);
    ins(6'b000000, 6'b001000);
    cyc("jr_f", F);
    cyc("jr_d", 16'b1000_00_00_00_00_11_10);
    ins(6'b000000, 6'b000000);
    cyc("nop_f", F);
    cyc("nop_d", DONE);
    ins(6'b111111, 6'b000000);
    cyc("und_f", F);
    chk("und0_d", o0, ILL);
    cyc("und_d", DONE);
    chk("und0_hold1", o0, ILL);
    cyc("und_f2", F);
    chk("und0_hold2", o0, ILL);
    reset = 1'b1;
    #1;
    chk("und0_rst", o0, Z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("und0_restart", o0, F);
    ins(6'b101011, 6'b000000);
    cyc("swr_f", F);
    cyc("swr_d", Z);
    cyc("swr_e", 16'b0000_11_00_00_00_00_00);
    chk("swr_m", o, 16'b0001_11_00_00_00_00_10);
    reset = 1'b1;
    #1;
    chk("swr_rst", o, Z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    ins(6'b000000, 6'b100001);
    cyc("post_f", F);
    cyc("post_d", Z);
    cyc("post_e", Z);
    cyc("post_wb", 16'b0010_00_00_01_00_00_10);
    chk("post_f2", o, F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
